spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_arbiter_if.sv | 36 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/spi_arbiter.sv | 144 ++++++++++++++
 tb/tb_spi_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding, parameter defaults and length decode for spi_arbiter
// Purpose: types and constants common to spi_arbiter and its sub-modules.
// Contents: state_t (arbiter FSM states), CS_GAP_DEFAULT, TIMEOUT_DEFAULT, len_decode().
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_FINISH,
    ST_GAP
  } state_t;

  localparam int CS_GAP_DEFAULT  = 4;
  localparam int TIMEOUT_DEFAULT = 4096;

  // A 4-bit length field of zero encodes a full 16-byte burst.
  function automatic logic [4:0] len_decode(input logic [3:0] len);
    return (len == 4'd0) ? 5'd16 : {1'b0, len};
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// rtl/spi_arbiter_if.sv - requester and SPI byte-engine bundle for spi_arbiter
// Purpose: groups the per-requester handshake and the shared engine signals.
// Modports: slave  - the arbiter (takes requests, drives grants and the engine)
//           master - requesters plus engine model (drive requests and engine status)
// Signals:  req/req_len/tx_data/tx_ack/rx_data/rx_valid/gnt/done/err/cs_n per requester,
//           spi_start/spi_tx/spi_cs/spi_rx towards the byte engine.
interface spi_arbiter_if #(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] req_len;
  logic [8*N_REQ-1:0] tx_data;
  logic [N_REQ-1:0]   tx_ack;
  logic [7:0]         rx_data;
  logic [N_REQ-1:0]   rx_valid;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   err;
  logic [N_REQ-1:0]   cs_n;
  logic               spi_start;
  logic [7:0]         spi_tx;
  logic               spi_cs;
  logic [7:0]         spi_rx;

  modport slave (
    input  req, req_len, tx_data, spi_cs, spi_rx,
    output tx_ack, rx_data, rx_valid, gnt, done, err, cs_n, spi_start, spi_tx
  );

  modport master (
    output req, req_len, tx_data, spi_cs, spi_rx,
    input  tx_ack, rx_data, rx_valid, gnt, done, err, cs_n, spi_start, spi_tx
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a priority pointer
// Purpose: returns the first set req bit scanning upward from ptr with wrap.
// Ports: req (N) request vector, ptr (PW) highest-priority index, grant (N) one-hot or zero.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit so ptr+i cannot overflow before the modulo-N wrap.
      w_sum = {1'b0, ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      w_idx = w_sum[PW-1:0];
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin sharing of one SPI byte engine among N_REQ requesters
// Purpose: grants whole bursts, sequences bytes through the engine, enforces CS_GAP idle
//          cycles between bursts. Optional per-byte watchdog when SPI_ARB_TIMEOUT_EN is defined.
// Ports: clk, rst_n (async active-low), bus (spi_arbiter_if.slave: requester + engine signals).
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CS_GAP  = CS_GAP_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_arbiter_if.slave   bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  state_t           r_state, w_next;
  logic [PW-1:0]    r_ptr, r_win, w_win, w_ptr_next;
  logic [N_REQ-1:0] r_gnt, w_grant, r_rx_valid;
  logic [4:0]       r_len, r_cnt;
  logic [GW-1:0]    r_gap;
  logic [7:0]       r_rx_data, w_tx_byte;
  logic [3:0]       w_req_len;
  logic             w_busy, w_timeout;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req   (bus.req),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // Index of the fresh winner (for latching its length) and byte of the current owner.
  always_comb begin
    w_win     = '0;
    w_req_len = '0;
    w_tx_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_win     = PW'(i);
        w_req_len = bus.req_len[i*4 +: 4];
      end
      if (r_win == PW'(i)) w_tx_byte = bus.tx_data[i*8 +: 8];
    end
  end

  assign w_ptr_next = (r_win == PW'(N_REQ-1)) ? '0 : r_win + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wdog;

  // Restarted for every byte in SETUP, so the limit applies per byte, not per burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state == ST_SETUP) begin
      r_wdog <= '0;
    end else if (r_state == ST_WAIT_LOW || r_state == ST_WAIT_HIGH) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_WAIT_LOW || r_state == ST_WAIT_HIGH) &&
                     (r_wdog == TW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_win      <= '0;
      r_gnt      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_gap      <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= '0;
    end else begin
      r_state    <= w_next;
      r_rx_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|bus.req) begin
            r_gnt <= w_grant;
            r_win <= w_win;
            r_len <= len_decode(w_req_len);
            r_cnt <= '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (bus.spi_cs && !w_timeout) begin
            r_rx_data  <= bus.spi_rx;
            r_rx_valid <= r_gnt;
            r_cnt      <= r_cnt + 5'd1;
          end
        end
        ST_FINISH: begin
          r_ptr <= w_ptr_next;
          r_gap <= '0;
        end
        ST_GAP:  r_gap <= r_gap + 1'b1;
        default: ;
      endcase
      if (w_timeout) begin
        r_ptr <= w_ptr_next;
        r_gap <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (|bus.req) w_next = ST_SETUP;
      ST_SETUP:     w_next = ST_WAIT_LOW;
      ST_WAIT_LOW:  if (!bus.spi_cs) w_next = ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (bus.spi_cs) w_next = (r_cnt + 5'd1 == r_len) ? ST_FINISH : ST_SETUP;
      ST_FINISH:    w_next = ST_GAP;
      ST_GAP:       if (r_gap == GW'(CS_GAP - 1)) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_GAP;
  end

  // Ownership is visible only while a burst is active; FINISH and GAP already show cs_n high.
  always_comb begin
    w_busy        = (r_state == ST_SETUP) || (r_state == ST_WAIT_LOW) || (r_state == ST_WAIT_HIGH);
    bus.gnt       = w_busy ? r_gnt : '0;
    bus.cs_n      = ~bus.gnt;
    bus.spi_start = (r_state == ST_SETUP);
    bus.spi_tx    = (r_state == ST_SETUP) ? w_tx_byte : '0;
    bus.tx_ack    = (r_state == ST_SETUP) ? r_gnt : '0;
    bus.done      = (r_state == ST_FINISH) ? r_gnt : '0;
    bus.err       = w_timeout ? r_gnt : '0;
    bus.rx_data   = r_rx_data;
    bus.rx_valid  = r_rx_valid;
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - scoreboard bench for spi_arbiter with a 20-cycle SPI engine model
module tb_spi_arbiter;

  localparam int N   = 4;
  localparam int GAP = 4;
  localparam int TO  = 64;

  localparam int EV_START = 0;
  localparam int EV_RXV   = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERR   = 3;

  typedef struct {
    int         kind;
    int         id;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_arbiter_if #(.N_REQ(N)) u_if ();

  spi_arbiter #(.N_REQ(N), .CS_GAP(GAP), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         start_cnt = 0, rxv_cnt = 0, done_cnt = 0, err_cnt = 0;
  int         cyc = 0, last_start_cyc = 0, last_err_cyc = 0, idle_run = 0;
  bit         mon_en = 1'b0, eng_dead = 1'b0, seen_low = 1'b0;
  logic [7:0] eng_b;
  logic [N-1:0] not_gnt, not_ack;

  function automatic logic [7:0] txb(input int id);
    return 8'hA0 + 8'(id);
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int cnt_of(input int which);
    case (which)
      EV_START: return start_cnt;
      EV_RXV:   return rxv_cnt;
      EV_DONE:  return done_cnt;
      default:  return err_cnt;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input int kind, input int id);
    ev_t e;
    e.kind = kind;
    e.id   = id;
    e.data = (kind == EV_START) ? txb(id) : (kind == EV_RXV) ? (txb(id) ^ 8'h5A) : 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic push_burst(input int id, input int len);
    for (int b = 0; b < len; b++) begin
      push(EV_START, id);
      push(EV_RXV, id);
    end
    push(EV_DONE, id);
  endtask

  task automatic sb_pop(input int kind, input int id, input logic [7:0] data, input string name);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event id=%0d data=%02h, nothing expected", name, id, data);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.id != id || e.data !== data) begin
      errors++;
      $display("FAIL %s: got kind=%0d id=%0d data=%02h expected kind=%0d id=%0d data=%02h",
               name, kind, id, data, e.kind, e.id, e.data);
    end
  endtask

  task automatic wait_evt(input int which, input int target, input int budget, input string name);
    int t = 0;
    while (cnt_of(which) < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(cnt_of(which) >= target), 32'd1);
  endtask

  task automatic wait_gnt(input int id, input string name);
    int t = 0;
    while (!u_if.gnt[id] && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(u_if.gnt[id]), 32'd1);
  endtask

  task automatic set_len(input int id, input int len);
    u_if.req_len[id*4 +: 4] = 4'(len);
  endtask

  // Monitor: invariants every cycle, scoreboard pops on every output pulse.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      seen_low = 1'b0;
      idle_run = 0;
    end else begin
      not_gnt = ~u_if.gnt;
      not_ack = ~u_if.tx_ack;
      check("cs_onehot", 32'($countones(~u_if.cs_n) <= 1), 32'd1);
      check("cs_vs_gnt", 32'(u_if.cs_n), 32'(not_gnt));
      check("ack_vs_start", 32'(|u_if.tx_ack), 32'(u_if.spi_start));
      if (u_if.cs_n != '1) begin
        if (seen_low && idle_run > 0) check("cs_gap", 32'(idle_run >= GAP), 32'd1);
        seen_low = 1'b1;
        idle_run = 0;
      end else begin
        idle_run++;
      end
      if (u_if.rx_valid != '0) begin
        rxv_cnt++;
        if (mon_en) sb_pop(EV_RXV, oh_idx(u_if.rx_valid), u_if.rx_data, "rx_valid");
      end
      if (u_if.spi_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        if (mon_en) begin
          sb_pop(EV_START, oh_idx(u_if.tx_ack), u_if.spi_tx, "spi_start");
          check("cs_at_start", 32'(u_if.cs_n), 32'(not_ack));
        end
      end
      if (u_if.done != '0) begin
        done_cnt++;
        if (mon_en) sb_pop(EV_DONE, oh_idx(u_if.done), 8'h00, "done");
      end
      if (u_if.err != '0) begin
        err_cnt++;
        last_err_cyc = cyc;
        if (mon_en) sb_pop(EV_ERR, oh_idx(u_if.err), 8'h00, "err");
      end
    end
  end

  // Byte engine: cs low 2 cycles after start, high again 18 cycles later with tx^0x5A.
  initial begin
    u_if.spi_cs = 1'b1;
    u_if.spi_rx = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && u_if.spi_start && !eng_dead) begin
        eng_b = u_if.spi_tx;
        repeat (2) @(negedge clk);
        u_if.spi_cs = 1'b0;
        repeat (18) @(negedge clk);
        u_if.spi_rx = eng_b ^ 8'h5A;
        u_if.spi_cs = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int s;
    int d;
    u_if.req     = '0;
    u_if.req_len = '0;
    for (int i = 0; i < N; i++) u_if.tx_data[i*8 +: 8] = txb(i);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_gnt",       32'(u_if.gnt),       32'h0);
    check("rst_cs_n",      32'(u_if.cs_n),      32'hF);
    check("rst_spi_start", 32'(u_if.spi_start), 32'h0);
    check("rst_spi_tx",    32'(u_if.spi_tx),    32'h0);
    check("rst_rx_data",   32'(u_if.rx_data),   32'h0);
    check("rst_tx_ack",    32'(u_if.tx_ack),    32'h0);
    check("rst_rx_valid",  32'(u_if.rx_valid),  32'h0);
    check("rst_done",      32'(u_if.done),      32'h0);
    check("rst_err",       32'(u_if.err),       32'h0);

    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single burst, requester 1, 3 bytes; request dropped once granted.
    push_burst(1, 3);
    set_len(1, 3);
    t = done_cnt + 1;
    u_if.req[1] = 1'b1;
    wait_gnt(1, "gnt1_single");
    u_if.req[1] = 1'b0;
    wait_evt(EV_DONE, t, 400, "done_single");
    repeat (8) @(negedge clk);

    // Requester 3, 4 bytes, request dropped after the first byte.
    push_burst(3, 4);
    set_len(3, 4);
    t = done_cnt + 1;
    s = rxv_cnt + 1;
    u_if.req[3] = 1'b1;
    wait_evt(EV_RXV, s, 100, "rxv_first_drop");
    u_if.req[3] = 1'b0;
    wait_evt(EV_DONE, t, 400, "done_drop");
    repeat (8) @(negedge clk);

    // Length 0 means 16 bytes.
    push_burst(2, 16);
    set_len(2, 0);
    t = done_cnt + 1;
    u_if.req[2] = 1'b1;
    wait_gnt(2, "gnt2_len0");
    u_if.req[2] = 1'b0;
    wait_evt(EV_DONE, t, 1000, "done_len0");
    repeat (8) @(negedge clk);

    // Reset during byte 2 of 5.
    mon_en = 1'b0;
    set_len(1, 5);
    s = start_cnt + 2;
    d = done_cnt;
    u_if.req[1] = 1'b1;
    wait_evt(EV_START, s, 100, "second_start");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    u_if.req[1] = 1'b0;
    #1;
    check("midrst_cs_n", 32'(u_if.cs_n), 32'hF);
    check("midrst_gnt",  32'(u_if.gnt),  32'h0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_done", 32'(u_if.done), 32'h0);
    end
    repeat (30) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'(d));
    mon_en = 1'b1;

    // Contention: all four requesting, pointer back at 0 after reset.
    push_burst(0, 1);
    push_burst(1, 1);
    push_burst(2, 1);
    push_burst(3, 1);
    push_burst(0, 1);
    for (int i = 0; i < N; i++) set_len(i, 1);
    t = done_cnt + 5;
    u_if.req = 4'b1111;
    wait_evt(EV_DONE, t, 1000, "done_contention");
    u_if.req = '0;
    repeat (10) @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
    // Engine never drops cs: requester 1 times out, requester 2 is served next.
    push(EV_START, 1);
    push(EV_ERR, 1);
    push_burst(2, 1);
    eng_dead = 1'b1;
    s = err_cnt + 1;
    t = done_cnt + 1;
    u_if.req = 4'b0110;
    wait_evt(EV_ERR, s, 300, "err_wdog");
    eng_dead = 1'b0;
    u_if.req[1] = 1'b0;
    check("wdog_latency", 32'(last_err_cyc - last_start_cyc), 32'd64);
    wait_gnt(2, "gnt2_after_err");
    u_if.req[2] = 1'b0;
    wait_evt(EV_DONE, t, 400, "done_after_err");
    repeat (8) @(negedge clk);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
